mincore_fetch: RTL

- Parametrised instruction-fetch front end for the next-generation mincore.
- Decouples instruction memory from the core with a valid/ready request channel and a wait-state-tolerant response channel.
- Supports up to DEPTH requests in flight and a DEPTH-entry prefetch FIFO.
- A redirect flushes the FIFO and discards all stale responses still in flight. Sits between imem and the decode stage.

---
 rtl/mincore_fetch_pkg.sv | 15 +
 rtl/mincore_fetch_fifo.sv | 53 +++++
 rtl/mincore_fetch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mincore_fetch_pkg.sv
// Shared definitions for the mincore fetch front end: state encodings, PC step, default reset PC.
// The align-check feature is selected with MINCORE_FETCH_ALIGN_CHECK_EN.
package mincore_fetch_pkg;

    localparam int MINCORE_FETCH_STATE_W = 1;

    typedef enum logic [MINCORE_FETCH_STATE_W-1:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    localparam int          PC_INC           = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/mincore_fetch_fifo.sv
// Synchronous FIFO with wrap-bit pointers, flush and occupancy count.
// Flush takes priority over push and pop in the same cycle.
module mincore_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/mincore_fetch.sv
// Instruction-fetch front end: issues imem requests, queues returned words with their PCs,
// and flushes/drops stale data on redirect. Optional MINCORE_FETCH_ALIGN_CHECK_EN adds fetch_fault.
module mincore_fetch
    import mincore_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_fault
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = DATA_W + ADDR_W;

    fetch_state_t       state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  redirect_target;
    logic [ADDR_W-1:0]  pcq_head;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   pcq_count;
    logic [CNT_W:0]     occupancy;
    logic [ENTRY_W-1:0] head;
    logic               fire;
    logic               accept_rsp;
    logic               inst_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pcq_empty;
    logic               pcq_full;

`ifdef MINCORE_FETCH_ALIGN_CHECK_EN
    logic fault;
    logic misaligned;
    assign redirect_target = redirect_pc;
    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign fetch_fault     = fault;
`else
    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    assign fetch_fault     = 1'b0;
`endif

    // Requests already in flight count against the FIFO space their data will need.
    assign occupancy      = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && (state == RUN) && !redirect_valid &&
                            (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign fire           = imem_req_valid && imem_req_ready;
    assign accept_rsp     = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid &&
                            (state == RUN);

    assign inst_valid = !fifo_empty;
    assign inst_pop   = inst_valid && inst_ready && !redirect_valid;
    assign inst_data  = inst_valid ? head[ADDR_W +: DATA_W] : '0;
    assign inst_pc    = inst_valid ? head[ADDR_W-1:0] : '0;

    mincore_fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (accept_rsp),
        .push_data ({imem_rsp_rdata, pcq_head}),
        .pop       (inst_pop),
        .head_data (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    mincore_fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fire),
        .push_data (fetch_pc),
        .pop       (accept_rsp),
        .head_data (pcq_head),
        .count     (pcq_count),
        .empty     (pcq_empty),
        .full      (pcq_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
`ifdef MINCORE_FETCH_ALIGN_CHECK_EN
            fault       <= 1'b0;
`endif
        end else begin
            outstanding <= outstanding + CNT_W'(fire) - CNT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                // Everything still in flight (minus this cycle's return) is stale.
                fetch_pc <= redirect_target;
                drop_cnt <= outstanding - CNT_W'(imem_rsp_valid);
`ifdef MINCORE_FETCH_ALIGN_CHECK_EN
                if (misaligned) begin
                    state <= FAULT;
                    fault <= 1'b1;
                end else begin
                    state <= RUN;
                    fault <= 1'b0;
                end
`endif
            end else begin
                if (fire) fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
                if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    a_rsp_has_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != '0));
    a_accept_has_room: assert property (@(posedge clk) disable iff (rst)
        accept_rsp |-> (!fifo_full && !pcq_empty));
    a_fire_has_room: assert property (@(posedge clk) disable iff (rst)
        fire |-> !pcq_full);
    a_counts_bounded: assert property (@(posedge clk) disable iff (rst)
        (pcq_count <= outstanding) && (outstanding <= CNT_W'(DEPTH)));

endmodule
